glitch_sequencer: RTL and testbench

//  Parametrised successor to the single-shot form glitcher: arm, wait for a qualified trigger edge, delay,

---
 rtl/glitch_pkg.sv | 14 +
 rtl/glitch_sequencer_edge_sync.sv | 33 +++
 rtl/glitch_sequencer.sv | 177 +++++++++++++++++
 tb/tb_glitch_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pkg.sv
// Shared constants for the glitch sequencer: FSM state codes and trigger edge selectors.
package glitch_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_DELAY = 3'd2;
  localparam logic [2:0] ST_FIRE  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/glitch_sequencer_edge_sync.sv
// Trigger synchroniser followed by a selectable rising/falling edge detector.
// The pulse is combinational from the last two synchronised samples and lasts one cycle.
module edge_sync
  import glitch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  input  logic sel,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   cur;

  assign cur = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trig};
      prev_q <= cur;
    end
  end

  assign pulse = (sel == EDGE_FALL) ? (prev_q & ~cur) : (cur & ~prev_q);

endmodule

// File: rtl/glitch_sequencer.sv
// Armed, edge-triggered glitch player: delay, then a programmable bit-form repeated with gaps.
// Configuration is captured into shadow registers at arm so the inputs are free afterwards.
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int FORM_W      = 64,
  parameter int DELAY_W     = 32,
  parameter int REPEAT_W    = 8,
  parameter int GAP_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         arm,
  input  logic                         abort,
  input  logic                         trig_in,
  input  logic                         trig_edge,
  input  logic [FORM_W-1:0]            cfg_form,
  input  logic [$clog2(FORM_W+1)-1:0]  cfg_len,
  input  logic [DELAY_W-1:0]           cfg_delay,
  input  logic [REPEAT_W-1:0]          cfg_repeat,
  input  logic [GAP_W-1:0]             cfg_gap,
  output logic                         glitch_out,
  output logic                         armed,
  output logic                         busy,
  output logic                         done,
  output logic [REPEAT_W-1:0]          plays_done
);

  localparam int LEN_W = $clog2(FORM_W+1);

  logic [2:0]          state_q, state_d;
  logic [FORM_W-1:0]   form_q, shift_q, shift_d;
  logic [LEN_W-1:0]    len_q, bits_q, bits_d;
  logic [DELAY_W-1:0]  delay_q, dcnt_q, dcnt_d;
  logic [GAP_W-1:0]    gap_q, gcnt_q, gcnt_d;
  logic [REPEAT_W-1:0] repeat_q, plays_q, plays_d, play_base;
  logic                edge_q, glitch_q, glitch_d;
  logic                load_cfg, start_play, finish_play, edge_pulse;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .trig  (trig_in),
    .sel   (edge_q),
    .pulse (edge_pulse)
  );

  // A zero-length play completes in the same cycle it starts, so start_play is
  // resolved after finish_play and may itself jump straight to GAP or DONE.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bits_d      = bits_q;
    dcnt_d      = dcnt_q;
    gcnt_d      = gcnt_q;
    plays_d     = plays_q;
    play_base   = plays_q;
    glitch_d    = 1'b0;
    load_cfg    = 1'b0;
    start_play  = 1'b0;
    finish_play = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          load_cfg = 1'b1;
          plays_d  = '0;
          state_d  = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (edge_pulse) begin
          if (delay_q != '0) begin
            state_d = ST_DELAY;
            dcnt_d  = delay_q - DELAY_W'(1);
          end else begin
            start_play = 1'b1;
          end
        end
      end
      ST_DELAY: begin
        if (dcnt_q == '0) start_play = 1'b1;
        else              dcnt_d = dcnt_q - DELAY_W'(1);
      end
      ST_FIRE: begin
        if (bits_q > LEN_W'(1)) begin
          shift_d = {shift_q[0], shift_q[FORM_W-1:1]};
          bits_d  = bits_q - LEN_W'(1);
        end else begin
          finish_play = 1'b1;
        end
      end
      ST_GAP: begin
        if (gcnt_q == '0) start_play = 1'b1;
        else              gcnt_d = gcnt_q - GAP_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (finish_play) begin
      play_base = plays_q + REPEAT_W'(1);
      plays_d   = play_base;
      if (play_base >= repeat_q) begin
        state_d = ST_DONE;
      end else if (gap_q != '0) begin
        state_d = ST_GAP;
        gcnt_d  = gap_q - GAP_W'(1);
      end else begin
        start_play = 1'b1;
      end
    end

    if (start_play) begin
      if (len_q != '0) begin
        state_d = ST_FIRE;
        shift_d = form_q;
        bits_d  = len_q;
      end else if (gap_q == '0) begin
        plays_d = repeat_q;
        state_d = ST_DONE;
      end else begin
        plays_d = play_base + REPEAT_W'(1);
        gcnt_d  = gap_q - GAP_W'(1);
        state_d = (plays_d >= repeat_q) ? ST_DONE : ST_GAP;
      end
    end

    if (state_d == ST_FIRE) glitch_d = shift_d[0];
  end

  // Abort wins over everything else but leaves plays_done and the shadow config alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      form_q   <= '0;
      len_q    <= '0;
      delay_q  <= '0;
      gap_q    <= '0;
      repeat_q <= '0;
      edge_q   <= EDGE_RISE;
      shift_q  <= '0;
      bits_q   <= '0;
      dcnt_q   <= '0;
      gcnt_q   <= '0;
      plays_q  <= '0;
      glitch_q <= 1'b0;
    end else if (abort) begin
      state_q  <= ST_IDLE;
      glitch_q <= 1'b0;
    end else begin
      if (load_cfg) begin
        form_q   <= cfg_form;
        len_q    <= (cfg_len > LEN_W'(FORM_W)) ? LEN_W'(FORM_W) : cfg_len;
        delay_q  <= cfg_delay;
        gap_q    <= cfg_gap;
        repeat_q <= (cfg_repeat == '0) ? REPEAT_W'(1) : cfg_repeat;
        edge_q   <= trig_edge;
      end
      state_q  <= state_d;
      shift_q  <= shift_d;
      bits_q   <= bits_d;
      dcnt_q   <= dcnt_d;
      gcnt_q   <= gcnt_d;
      plays_q  <= plays_d;
      glitch_q <= glitch_d;
    end
  end

  assign glitch_out = glitch_q;
  assign armed      = (state_q == ST_ARMED);
  assign busy       = (state_q == ST_DELAY) || (state_q == ST_FIRE) || (state_q == ST_GAP);
  assign done       = (state_q == ST_DONE);
  assign plays_done = plays_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Randomised and directed bench for glitch_sequencer against a cycle-list reference model.
module tb_glitch_sequencer;

  localparam int FORM_W      = 64;
  localparam int DELAY_W     = 32;
  localparam int REPEAT_W    = 8;
  localparam int GAP_W       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int LEN_W       = $clog2(FORM_W+1);

  logic                clk, rst_n, arm, abort, trig_in, trig_edge;
  logic [FORM_W-1:0]   cfg_form;
  logic [LEN_W-1:0]    cfg_len;
  logic [DELAY_W-1:0]  cfg_delay;
  logic [REPEAT_W-1:0] cfg_repeat;
  logic [GAP_W-1:0]    cfg_gap;
  logic                glitch_out, armed, busy, done;
  logic [REPEAT_W-1:0] plays_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected per-cycle {glitch_out, busy, done, plays_done} from the cycle after edge detect.
  logic [10:0] exp_q[$];
  int          exp_plays_final;

  glitch_sequencer #(
    .FORM_W(FORM_W), .DELAY_W(DELAY_W), .REPEAT_W(REPEAT_W),
    .GAP_W(GAP_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig_in(trig_in),
    .trig_edge(trig_edge), .cfg_form(cfg_form), .cfg_len(cfg_len),
    .cfg_delay(cfg_delay), .cfg_repeat(cfg_repeat), .cfg_gap(cfg_gap),
    .glitch_out(glitch_out), .armed(armed), .busy(busy), .done(done),
    .plays_done(plays_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic build_model(input logic [FORM_W-1:0] form, input int len, input int delay,
                             input int rep, input int gap);
    int len_eff, rep_eff, plays;
    len_eff = (len > FORM_W) ? FORM_W : len;
    rep_eff = (rep == 0) ? 1 : rep;
    plays   = 0;
    exp_q.delete();
    for (int i = 0; i < delay; i++) exp_q.push_back({1'b0, 1'b1, 1'b0, 8'(plays)});
    for (int p = 0; p < rep_eff; p++) begin
      for (int i = 0; i < len_eff; i++) exp_q.push_back({form[i], 1'b1, 1'b0, 8'(plays)});
      plays++;
      if (p < rep_eff - 1)
        for (int i = 0; i < gap; i++) exp_q.push_back({1'b0, 1'b1, 1'b0, 8'(plays)});
    end
    exp_q.push_back({1'b0, 1'b0, 1'b1, 8'(plays)});
    exp_plays_final = plays;
  endtask

  task automatic do_arm(input logic [FORM_W-1:0] form, input int len, input int delay,
                        input int rep, input int gap, input logic edge_sel);
    @(negedge clk);
    cfg_form   = form;
    cfg_len    = LEN_W'(len);
    cfg_delay  = DELAY_W'(delay);
    cfg_repeat = REPEAT_W'(rep);
    cfg_gap    = GAP_W'(gap);
    trig_edge  = edge_sel;
    arm        = 1'b1;
    @(negedge clk);
    arm        = 1'b0;
    cfg_form   = {$urandom, $urandom};
    cfg_len    = LEN_W'($urandom);
    cfg_delay  = DELAY_W'($urandom);
    cfg_repeat = REPEAT_W'($urandom);
    cfg_gap    = GAP_W'($urandom);
    trig_edge  = 1'($urandom);
    n_checks++;
    if (armed !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL arm_accept: armed=%b busy=%b, expected armed=1 busy=0", armed, busy);
    end
  endtask

  // Settle the inactive level, arm, produce one active edge and stop at the first model cycle.
  task automatic start_seq(input logic [FORM_W-1:0] form, input int len, input int delay,
                           input int rep, input int gap, input logic edge_sel);
    build_model(form, len, delay, rep, gap);
    @(negedge clk);
    trig_in = edge_sel;
    repeat (4) @(negedge clk);
    do_arm(form, len, delay, rep, gap, edge_sel);
    repeat (2) @(negedge clk);
    trig_in = ~edge_sel;
    repeat (SYNC_STAGES + 1) @(negedge clk);
  endtask

  task automatic check_trace(input string name, input bit disturb);
    logic [10:0] got;
    int n;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      got = {glitch_out, busy, done, plays_done};
      n_checks++;
      if (got !== exp_q[k]) begin
        n_fail++;
        $display("[TB] FAIL %s[%0d]: got g/b/d/plays=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
                 name, k, got[10], got[9], got[8], got[7:0],
                 exp_q[k][10], exp_q[k][9], exp_q[k][8], exp_q[k][7:0]);
      end
      if (disturb && k < 4) trig_in = ~trig_in;
      @(negedge clk);
    end
    got = {glitch_out, busy, done, plays_done};
    n_checks++;
    if (got !== {3'b000, 8'(exp_plays_final)} || armed !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s_idle: got g/b/d/plays=%b/%b/%b/%0d armed=%b, expected 0/0/0/%0d armed=0",
               name, got[10], got[9], got[8], got[7:0], armed, exp_plays_final);
    end
  endtask

  task automatic run_seq(input string name, input logic [FORM_W-1:0] form, input int len,
                         input int delay, input int rep, input int gap, input logic edge_sel);
    start_seq(form, len, delay, rep, gap, edge_sel);
    check_trace(name, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trig_in = 1'b0; trig_edge = 1'b0;
    cfg_form = '0; cfg_len = '0; cfg_delay = '0; cfg_repeat = '0; cfg_gap = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({glitch_out, armed, busy, done, plays_done} !== 12'h000) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got g/a/b/d/plays=%b/%b/%b/%b/%0d, expected all 0",
               glitch_out, armed, busy, done, plays_done);
    end
    rst_n = 1'b1;
    start_seq({FORM_W{1'b1}}, FORM_W, 3, 1, 0, 1'b0);
    repeat (8) @(negedge clk);
    n_checks++;
    if (glitch_out !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_prefire: got g=%b b=%b, expected 1/1", glitch_out, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({glitch_out, busy, armed} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_async: got g/b/a=%b/%b/%b, expected 0/0/0", glitch_out, busy, armed);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({glitch_out, armed, busy, done, plays_done} !== 12'h000) begin
      n_fail++;
      $display("[TB] FAIL reset_release: got g/a/b/d/plays=%b/%b/%b/%b/%0d, expected all 0",
               glitch_out, armed, busy, done, plays_done);
    end
  endtask

  task automatic test_basic();
    run_seq("basic", 64'b1011, 4, 10, 1, $urandom_range(0, 9), 1'b0);
  endtask

  task automatic test_repeat();
    run_seq("repeat", 64'b11, 2, 0, 3, 2, 1'b0);
  endtask

  task automatic test_edge_select();
    // Rising select with the line already high: no edge, must stay armed.
    @(negedge clk);
    trig_in = 1'b1;
    repeat (4) @(negedge clk);
    do_arm(64'hF, 4, 0, 1, 0, 1'b0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (armed !== 1'b1 || busy !== 1'b0 || glitch_out !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL level_rise: got a/b/g=%b/%b/%b, expected 1/0/0", armed, busy, glitch_out);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    // Falling select: the high level is no edge; the first fall fires, later edges are ignored.
    build_model(64'hA5, 8, 8, 1, 0);
    do_arm(64'hA5, 8, 8, 1, 0, 1'b1);
    repeat (8) @(negedge clk);
    n_checks++;
    if (armed !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL level_fall: got a/b=%b/%b, expected 1/0", armed, busy);
    end
    trig_in = 1'b0;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    check_trace("edge_fall", 1'b1);
  endtask

  task automatic test_abort();
    bit bad;
    start_seq(64'hFFFF, 16, 1000, 1, 0, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL abort_predelay: got busy=%b, expected 1", busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if ({glitch_out, armed, busy, done} !== 4'b0000) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("[TB] FAIL abort_delay: got an active output after abort, expected g/a/b/d all 0");
    end
    // Abort in GAP after one play: plays_done must hold at 1.
    start_seq(64'h1, 1, 0, 3, 50, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, plays_done} !== {2'b00, 8'd1}) begin
      n_fail++;
      $display("[TB] FAIL abort_gap: got b/d/plays=%b/%b/%0d, expected 0/0/1", busy, done, plays_done);
    end
    // Abort and arm together: abort wins.
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    n_checks++;
    if (armed !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_arm: got armed=%b busy=%b, expected 0/0", armed, busy);
    end
  endtask

  task automatic test_clamps();
    run_seq("len_clamp", {$urandom, $urandom}, FORM_W + 5, 2, 1, 0, 1'b0);
    run_seq("rep_zero", 64'h2D, 6, 1, 0, 3, 1'b1);
    run_seq("len_zero", 64'hFF, 0, 3, 2, 3, 1'b0);
    run_seq("len_zero_gap0", 64'hFF, 0, 0, 3, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      run_seq($sformatf("rand%0d", it), {$urandom, $urandom}, $urandom_range(0, FORM_W + 6),
              $urandom_range(0, 15), $urandom_range(0, 4), $urandom_range(0, 6), 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    run_seq("b2b", 64'b101, 3, 0, 4, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_edge_select();
    test_abort();
    test_clamps();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
